// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch front end with req/ack memory port and decode hand-off.
// Optional feature macro: IFETCH_ALIGN_CHK_EN (misaligned PCs become NOP entries without a fetch).
`default_nettype none

module ifetch_unit #(
    parameter logic [31:0] NOP_INSTR = 32'h00000000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      pc_in,
    output logic             busy,
    input  logic             flush,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic [31:0]      instr_pc,
    output logic             instr_valid,
    input  logic             id_ready,
    output logic             fetch_misalign,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t           r_state;
    logic [31:0]      r_addr;
    logic [31:0]      r_instr;
    logic [31:0]      r_instr_pc;
    logic [CNT_W-1:0] r_stall;

    logic             w_launch;
    logic             w_misaligned;
    logic [31:0]      w_launch_addr;

    always_comb begin
        w_launch = 1'b0;
        case (r_state)
            S_IDLE:  w_launch = 1'b1;
            S_FETCH: w_launch = imem_ack & flush;
            S_VALID: w_launch = flush | id_ready;
            S_DROP:  w_launch = imem_ack;
            default: w_launch = 1'b0;
        endcase
    end

`ifdef IFETCH_ALIGN_CHK_EN
    logic r_misalign;

    assign w_misaligned   = |pc_in[1:0];
    assign w_launch_addr  = pc_in;
    assign fetch_misalign = r_misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else if (w_launch) begin
            r_misalign <= w_misaligned;
        end
    end
`else
    logic w_unused_pc_lsb;

    assign w_unused_pc_lsb = |pc_in[1:0];
    assign w_misaligned    = 1'b0;
    assign w_launch_addr   = {pc_in[31:2], 2'b00};
    assign fetch_misalign  = 1'b0;
`endif

    // A flush lets the PC register load its target; a hand-off lets it advance.
    assign busy = (r_state == S_IDLE) |
                  (~flush & ~((r_state == S_VALID) & id_ready));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= 32'h0;
            r_instr    <= 32'h0;
            r_instr_pc <= 32'h0;
            r_stall    <= '0;
        end else begin
            if ((r_state != S_VALID) && (r_stall != {CNT_W{1'b1}})) begin
                r_stall <= r_stall + 1'b1;
            end
            if (w_launch) begin
                r_addr <= w_launch_addr;
                if (w_misaligned) begin
                    r_state    <= S_VALID;
                    r_instr    <= NOP_INSTR;
                    r_instr_pc <= pc_in;
                end else begin
                    r_state <= S_FETCH;
                end
            end else if (r_state == S_FETCH) begin
                if (imem_ack) begin
                    r_state    <= S_VALID;
                    r_instr    <= imem_rdata;
                    r_instr_pc <= r_addr;
                end else if (flush) begin
                    r_state <= S_DROP;
                end
            end
        end
    end

    assign imem_req    = (r_state == S_FETCH) | (r_state == S_DROP);
    assign imem_addr   = r_addr;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = (r_state == S_VALID);
    assign stall_cnt   = r_stall;

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed checks of ifetch_unit against a PC-register and memory model.
`default_nettype none

module tb_ifetch_unit;

    localparam int          c_CNT_W = 4;
    localparam logic [31:0] c_NOP   = 32'h00000013;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [31:0]        pc;
    logic [31:0]        tgt;
    logic               busy;
    logic               flush;
    logic               imem_req;
    logic [31:0]        imem_addr;
    logic               imem_ack;
    logic [31:0]        imem_rdata;
    logic [31:0]        instr;
    logic [31:0]        instr_pc;
    logic               instr_valid;
    logic               id_ready;
    logic               fetch_misalign;
    logic [c_CNT_W-1:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int lat   = 1;
    int mcnt  = 0;

    ifetch_unit #(
        .NOP_INSTR (c_NOP),
        .CNT_W     (c_CNT_W)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_in          (pc),
        .busy           (busy),
        .flush          (flush),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .id_ready       (id_ready),
        .fetch_misalign (fetch_misalign),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    // PC register (falling-edge write) and a fixed-latency memory returning ~addr.
    always @(negedge clk) begin
        if (rst_n && !busy) pc = flush ? tgt : pc + 32'd4;
        if (!imem_req) begin
            mcnt     = 0;
            imem_ack = 1'b0;
        end else if (mcnt >= lat) begin
            imem_ack   = 1'b1;
            imem_rdata = ~imem_addr;
            mcnt       = 0;
        end else begin
            imem_ack = 1'b0;
            mcnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic saw_valid;

    initial begin
        rst_n = 1'b0; pc = 32'h00400000; tgt = 32'h0; flush = 1'b0; id_ready = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        repeat (3) tick();
        chk("rst_req",   {31'd0, imem_req},    32'd0);
        chk("rst_addr",  imem_addr,            32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr,                32'd0);
        chk("rst_stall", {28'd0, stall_cnt},   32'd0);
        chk("rst_busy",  {31'd0, busy},        32'd1);
        chk("rst_mis",   {31'd0, fetch_misalign}, 32'd0);

        rst_n = 1'b1;
        tick();
        chk("first_req",  {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr,         32'h00400000);
        chk("first_busy", {31'd0, busy},     32'd1);
        tick();
        chk("edge2_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("edge3_valid", {31'd0, instr_valid}, 32'd1);
        chk("edge3_instr", instr,                32'hFFBFFFFF);
        chk("edge3_pc",    instr_pc,             32'h00400000);
        chk("edge3_req",   {31'd0, imem_req},    32'd0);

        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_instr", instr,             32'hFFBFFFFF);
            chk("hold_busy",  {31'd0, busy},     32'd1);
            chk("hold_req",   {31'd0, imem_req}, 32'd0);
        end
        id_ready = 1'b1;
        #1 chk("handoff_busy", {31'd0, busy}, 32'd0);
        tick();
        id_ready = 1'b0;
        chk("next_addr",  imem_addr,            32'h00400004);
        chk("next_req",   {31'd0, imem_req},    32'd1);
        chk("next_valid", {31'd0, instr_valid}, 32'd0);

        lat = 3; flush = 1'b1; tgt = 32'h00500000;
        #1 chk("flush_busy", {31'd0, busy}, 32'd0);
        tick();
        flush = 1'b0;
        chk("drop_req",  {31'd0, imem_req}, 32'd1);
        chk("drop_addr", imem_addr,         32'h00400004);
        saw_valid = instr_valid;
        for (int i = 0; i < 10 && imem_addr != 32'h00500000; i++) begin
            tick();
            saw_valid = saw_valid | instr_valid;
        end
        chk("drop_no_valid", {31'd0, saw_valid}, 32'd0);
        chk("drop_new_addr", imem_addr,          32'h00500000);
        for (int i = 0; i < 10 && !instr_valid; i++) tick();
        chk("tgt_instr", instr,              32'hFFAFFFFF);
        chk("tgt_pc",    instr_pc,           32'h00500000);
        chk("tgt_stall", {28'd0, stall_cnt}, 32'd11);

        flush = 1'b1; id_ready = 1'b1; tgt = 32'h00600000; lat = 0;
        #1 chk("fr_busy", {31'd0, busy}, 32'd0);
        tick();
        flush = 1'b0; id_ready = 1'b0;
        chk("fr_addr",  imem_addr,            32'h00600000);
        chk("fr_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("minlat_valid", {31'd0, instr_valid}, 32'd1);
        chk("minlat_pc",    instr_pc,             32'h00600000);
        chk("minlat_stall", {28'd0, stall_cnt},   32'd12);

        lat = 1000; id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        chk("sat_addr", imem_addr, 32'h00600004);
        repeat (6) tick();
        chk("sat_cnt", {28'd0, stall_cnt}, 32'd15);
        tick();
        chk("sat_hold", {28'd0, stall_cnt}, 32'd15);
        chk("sat_req",  {31'd0, imem_req},  32'd1);

        #2 rst_n = 1'b0;
        #1;
        chk("async_req",   {31'd0, imem_req},    32'd0);
        chk("async_addr",  imem_addr,            32'd0);
        chk("async_stall", {28'd0, stall_cnt},   32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rel_req",   {31'd0, imem_req},  32'd1);
        chk("rel_addr",  imem_addr,          32'h00600004);
        chk("rel_stall", {28'd0, stall_cnt}, 32'd1);

        lat = 0;
        tick();
        chk("pre_mis_valid", {31'd0, instr_valid}, 32'd1);
        flush = 1'b1; tgt = 32'h00400002;
        tick();
        flush = 1'b0;
`ifdef IFETCH_ALIGN_CHK_EN
        chk("mis_req",   {31'd0, imem_req},       32'd0);
        chk("mis_valid", {31'd0, instr_valid},    32'd1);
        chk("mis_instr", instr,                   c_NOP);
        chk("mis_pc",    instr_pc,                32'h00400002);
        chk("mis_flag",  {31'd0, fetch_misalign}, 32'd1);
        flush = 1'b1; tgt = 32'h00400010;
        tick();
        flush = 1'b0;
        chk("mis_clear", {31'd0, fetch_misalign}, 32'd0);
        chk("mis_req2",  {31'd0, imem_req},       32'd1);
        chk("mis_addr2", imem_addr,               32'h00400010);
`else
        chk("mis_addr",  imem_addr,               32'h00400000);
        chk("mis_req",   {31'd0, imem_req},       32'd1);
        chk("mis_flag",  {31'd0, fetch_misalign}, 32'd0);
        tick();
        chk("mis_valid", {31'd0, instr_valid},    32'd1);
        chk("mis_pc",    instr_pc,                32'h00400000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
